f5_sweep_ctrl: RTL and testbench

//  Sequencer/arbiter for the 5-input combinational function unit f5_logic (F = (~A|B)&(CDE|~C~DE) | ~A~CD~E | ABCD).
//  On start, sweeps all 32 input vectors, captures the 32-bit truth table, counts minterms and checks against EXP_TABLE.

---
 rtl/f5_sweep_ctrl_pkg.sv | 22 ++
 rtl/f5_sweep_ctrl_f5_logic.sv | 20 ++
 rtl/f5_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_f5_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/f5_sweep_ctrl_pkg.sv
// Purpose: shared types and constants for the f5 truth-table sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package f5_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FIN     = 2'd3
    } state_t;

    localparam int N_VEC = 32;
    localparam int VEC_W = 5;

    // Last vector index of a sweep; reaching it sends the FSM to FIN.
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

    // Golden truth table: bit k = F for {A,B,C,D,E} = k, A is the MSB.
    localparam logic [N_VEC-1:0] DEF_EXP_TABLE = 32'hC2008686;

endpackage

// File: rtl/f5_sweep_ctrl_f5_logic.sv
// Purpose: the shared 5-input combinational function F(A,B,C,D,E).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module f5_logic (
    input  logic [4:0] vec,
    output logic       f
);
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;

    assign {a, b, c, d, e} = vec;

    assign f = ((~a | b) & ((c & d & e) | (~c & ~d & e)))
             | (~a & ~c & d & ~e)
             | (a & b & c & d);

endmodule

// File: rtl/f5_sweep_ctrl.sv
// Purpose: sweeps all 32 vectors through f5_logic, captures/checks the table; shares f5_logic with one external requester.
// Latency: start-to-done 32*(SETTLE+1)+1 cycles; external lookup result one cycle after grant.
// Backpressure: external requests are only granted in IDLE without a same-cycle start; requester holds ext_req until ext_gnt.
module f5_sweep_ctrl
    import f5_sweep_ctrl_pkg::*;
#(
    parameter int          SETTLE    = 0,
    parameter logic [31:0] EXP_TABLE = DEF_EXP_TABLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ext_req,
    input  logic [4:0]  ext_vec,
    output logic        ext_gnt,
    output logic        ext_valid,
    output logic        ext_f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  ones_cnt,
    output logic [31:0] tt_table,
    output logic [4:0]  cur_vec
);
    // Wait-counter terminal value; with SETTLE=0 the APPLY state is skipped entirely.
    localparam logic [2:0] SETTLE_LAST = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);
    localparam state_t     VEC_ENTRY   = (SETTLE == 0) ? ST_CAPTURE : ST_APPLY;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] wait_q;
    logic [5:0] acc_q;
    logic [5:0] acc_next;
    logic [4:0] f_vec;
    logic       f_out;
    logic       last_vec;

    assign busy     = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_FIN);
    assign f_vec    = busy ? cur_vec : ext_vec;
    assign last_vec = (cur_vec == LAST_VEC);
    assign acc_next = acc_q + {5'd0, f_out};

    f5_logic u_f5 (
        .vec (f_vec),
        .f   (f_out)
    );

    // Next-state and external grant; start takes priority over a same-cycle ext_req.
    always_comb begin
        state_d = state_q;
        ext_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = VEC_ENTRY;
                end else begin
                    ext_gnt = ext_req;
                end
            end
            ST_APPLY: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = last_vec ? ST_FIN : VEC_ENTRY;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, sweep datapath and external lookup registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= 3'd0;
            acc_q     <= 6'd0;
            cur_vec   <= 5'd0;
            tt_table  <= 32'd0;
            ones_cnt  <= 6'd0;
            pass      <= 1'b0;
            ext_f     <= 1'b0;
            ext_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ext_valid <= ext_gnt;
            if (ext_gnt) begin
                ext_f <= f_out;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_vec  <= 5'd0;
                        tt_table <= 32'd0;
                        acc_q    <= 6'd0;
                        wait_q   <= 3'd0;
                    end
                end
                ST_APPLY: begin
                    wait_q <= (wait_q == SETTLE_LAST) ? 3'd0 : wait_q + 3'd1;
                end
                ST_CAPTURE: begin
                    tt_table[cur_vec] <= f_out;
                    acc_q             <= acc_next;
                    if (last_vec) begin
                        // Results are published here so they are visible in the FIN (done) cycle.
                        ones_cnt <= acc_next;
                        pass     <= ({f_out, tt_table[30:0]} == EXP_TABLE);
                    end else begin
                        cur_vec <= cur_vec + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Purpose: directed self-checking bench for f5_sweep_ctrl (two parameterisations sharing stimulus).
// Latency: n/a.
// Backpressure: n/a.
module tb_f5_sweep_ctrl;

    localparam logic [31:0] GOLD = 32'hC2008686;

    typedef struct packed {
        logic [31:0] tab;
        logic [5:0]  ones;
        logic        pass;
    } sw_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ext_req;
    logic [4:0]  ext_vec;

    logic        a_ext_gnt, a_ext_valid, a_ext_f, a_busy, a_done, a_pass;
    logic [5:0]  a_ones;
    logic [31:0] a_tt;
    logic [4:0]  a_cur_vec;

    logic        b_ext_gnt, b_ext_valid, b_ext_f, b_busy, b_done, b_pass;
    logic [5:0]  b_ones;
    logic [31:0] b_tt;
    logic [4:0]  b_cur_vec;

    int n_chk  = 0;
    int n_fail = 0;

    sw_t  sb_a[$];
    sw_t  sb_b[$];
    logic ext_q[$];

    f5_sweep_ctrl u_a (
        .clk(clk), .rst(rst), .start(start), .ext_req(ext_req), .ext_vec(ext_vec),
        .ext_gnt(a_ext_gnt), .ext_valid(a_ext_valid), .ext_f(a_ext_f),
        .busy(a_busy), .done(a_done), .pass(a_pass), .ones_cnt(a_ones),
        .tt_table(a_tt), .cur_vec(a_cur_vec)
    );

    f5_sweep_ctrl #(.SETTLE(2), .EXP_TABLE(32'h0)) u_b (
        .clk(clk), .rst(rst), .start(start), .ext_req(ext_req), .ext_vec(ext_vec),
        .ext_gnt(b_ext_gnt), .ext_valid(b_ext_valid), .ext_f(b_ext_f),
        .busy(b_busy), .done(b_done), .pass(b_pass), .ones_cnt(b_ones),
        .tt_table(b_tt), .cur_vec(b_cur_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gold_f(input logic [4:0] v);
        logic [31:0] g;
        g = GOLD;
        return g[v];
    endfunction

    // Pulse start, then follow both instances to their done pulses and score the results.
    task automatic run_sweep(input string tag);
        int  c;
        int  da;
        int  db;
        sw_t e;
        sb_a.push_back(sw_t'{tab: GOLD, ones: 6'd9, pass: 1'b1});
        sb_b.push_back(sw_t'{tab: GOLD, ones: 6'd9, pass: 1'b0});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_a"}, a_busy, 1);
        chk({tag, "_busy_b"}, b_busy, 1);
        chk({tag, "_vec0_a"}, a_cur_vec, 0);
        chk({tag, "_tt_clr_a"}, a_tt, 0);
        c  = 0;
        da = 0;
        db = 0;
        while (c < 150 && (da == 0 || db == 0)) begin
            tick();
            c++;
            if (a_done && da == 0) begin
                da = c;
                if (sb_a.size() == 0) begin
                    chk({tag, "_sb_a_empty"}, 0, 1);
                end else begin
                    e = sb_a.pop_front();
                    chk({tag, "_tab_a"}, a_tt, e.tab);
                    chk({tag, "_ones_a"}, a_ones, e.ones);
                    chk({tag, "_pass_a"}, a_pass, e.pass);
                    chk({tag, "_busy_fin_a"}, a_busy, 0);
                end
            end
            if (b_done && db == 0) begin
                db = c;
                if (sb_b.size() == 0) begin
                    chk({tag, "_sb_b_empty"}, 0, 1);
                end else begin
                    e = sb_b.pop_front();
                    chk({tag, "_tab_b"}, b_tt, e.tab);
                    chk({tag, "_ones_b"}, b_ones, e.ones);
                    chk({tag, "_pass_b"}, b_pass, e.pass);
                end
            end
        end
        chk({tag, "_done_cyc_a"}, da, 32);
        chk({tag, "_done_cyc_b"}, db, 96);
        tick();
        chk({tag, "_done_pulse_b"}, b_done, 0);
        chk({tag, "_hold_vec_a"}, a_cur_vec, 31);
        chk({tag, "_hold_vec_b"}, b_cur_vec, 31);
        chk({tag, "_hold_tab_a"}, a_tt, GOLD);
        chk({tag, "_hold_pass_a"}, a_pass, 1);
    endtask

    initial begin
        int         c;
        int         ga;
        int         gb;
        logic       early;
        logic       pend;
        logic       found;
        logic       seen;
        logic [4:0] vecs [7];

        rst     = 1'b1;
        start   = 1'b0;
        ext_req = 1'b0;
        ext_vec = 5'd0;
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy_a", a_busy, 0);
        chk("rst_done_a", a_done, 0);
        chk("rst_pass_a", a_pass, 0);
        chk("rst_ones_a", a_ones, 0);
        chk("rst_tt_a", a_tt, 0);
        chk("rst_vec_a", a_cur_vec, 0);
        chk("rst_gnt_a", a_ext_gnt, 0);
        chk("rst_valid_a", a_ext_valid, 0);
        chk("rst_extf_a", a_ext_f, 0);
        chk("rst_busy_b", b_busy, 0);
        chk("rst_tt_b", b_tt, 0);
        tick();
        chk("idle_busy_a", a_busy, 0);
        chk("idle_done_a", a_done, 0);

        // Full sweeps: SETTLE=0 golden match and SETTLE=2 with an all-zero golden table
        run_sweep("sw1");

        // External lookups, back-to-back while ext_req is held
        ext_req = 1'b1;
        ext_vec = 5'b11110;
        #1;
        chk("ext_gnt_30", a_ext_gnt, 1);
        ext_q.push_back(1'b1);
        tick();
        chk("ext_valid_30", a_ext_valid, 1);
        chk("ext_f_30", a_ext_f, ext_q.pop_front());
        vecs = '{5'b00011, 5'd1, 5'd2, 5'd7, 5'd12, 5'd31, 5'd0};
        for (int i = 0; i < 7; i++) begin
            ext_vec = vecs[i];
            #1;
            chk($sformatf("ext_gnt_%0d", vecs[i]), a_ext_gnt, 1);
            ext_q.push_back(gold_f(vecs[i]));
            tick();
            chk($sformatf("ext_valid_%0d", vecs[i]), a_ext_valid, 1);
            chk($sformatf("ext_f_%0d", vecs[i]), a_ext_f, ext_q.pop_front());
        end
        ext_req = 1'b0;
        ext_vec = 5'd1;
        #1;
        chk("ext_nogrant", a_ext_gnt, 0);
        tick();
        chk("ext_valid_drop", a_ext_valid, 0);
        chk("ext_f_held", a_ext_f, 0);
        ext_vec = 5'b11110;
        tick();
        chk("ext_vec_noeffect", a_ext_f, 0);

        // start and ext_req in the same cycle: start wins, request waits for IDLE
        start   = 1'b1;
        ext_req = 1'b1;
        ext_vec = 5'b00001;
        #1;
        chk("coll_gnt_a", a_ext_gnt, 0);
        chk("coll_gnt_b", b_ext_gnt, 0);
        tick();
        start = 1'b0;
        c     = 0;
        ga    = 0;
        gb    = 0;
        early = 1'b0;
        pend  = 1'b0;
        while (c < 150 && gb == 0) begin
            tick();
            c++;
            if (pend) begin
                pend = 1'b0;
                chk("coll_valid_a", a_ext_valid, 1);
                chk("coll_f_a", a_ext_f, ext_q.pop_front());
            end
            if (a_busy && a_ext_gnt) early = 1'b1;
            if (a_ext_gnt && ga == 0) begin
                ga = c;
                ext_q.push_back(1'b1);
                pend = 1'b1;
            end
            if (b_ext_gnt && gb == 0) gb = c;
        end
        ext_req = 1'b0;
        chk("coll_gnt_cyc_a", ga, 33);
        chk("coll_gnt_cyc_b", gb, 97);
        chk("coll_gnt_busy", early, 0);
        tick();
        tick();

        // Reset in the middle of a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        c     = 0;
        while (!found && c < 60) begin
            if (a_cur_vec == 5'd12) begin
                found = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        chk("mid_find_vec12", found, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy_a", a_busy, 0);
        chk("mid_tt_a", a_tt, 0);
        chk("mid_done_a", a_done, 0);
        chk("mid_vec_a", a_cur_vec, 0);
        chk("mid_busy_b", b_busy, 0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (a_done || b_done) seen = 1'b1;
        end
        chk("mid_no_done", seen, 0);
        run_sweep("sw2");

        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);
        chk("ext_q_drained", ext_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
